match_controller: RTL and testbench

Sequencer for the Pong match. It owns the game-phase state machine: power-up warm-up, serve, rally, post-point pause and game-over. It generates the common `run` enable for ball, user paddle and AI paddle, a one-cycle `serve` pulse that re-launches the ball, and the registered scores and win flags used by the score/word renderers. It sits beside `pixel_gen` and replaces its free-running start counter and scoring logic. All delays count video frames, not clock cycles.

---
 rtl/match_controller_pkg.sv | 24 ++
 rtl/match_controller_if.sv | 29 ++
 rtl/match_controller_frame_timer.sv | 44 ++++
 rtl/match_controller.sv | 147 ++++++++++++++
 tb/tb_match_controller.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/match_controller_pkg.sv
// Shared types and constants for the Pong match sequencer.
package match_controller_pkg;

    // Game phases of a match.
    typedef enum logic [2:0] {
        MS_WARMUP,
        MS_SERVE,
        MS_PLAY,
        MS_PAUSE,
        MS_OVER
    } match_state_t;

    localparam int SCORE_W = 3;
    localparam int TIMER_W = 8;

    // Score increment that never passes the winning score.
    function automatic logic [SCORE_W-1:0] sat_inc(
        input logic [SCORE_W-1:0] score,
        input logic [SCORE_W-1:0] limit
    );
        return (score >= limit) ? limit : score + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/match_controller_if.sv
// Bundle between the pixel pipeline (master) and the match sequencer (slave).
interface match_controller_if;
    import match_controller_pkg::*;

    logic               en;
    logic               frame_tick;
    logic               point_left;
    logic               point_right;
    logic               restart;
    logic               run;
    logic               serve;
    logic               serve_dir;
    logic [SCORE_W-1:0] s1;
    logic [SCORE_W-1:0] s2;
    logic               gameover;
    logic               win_left;
    logic               win_right;

    modport master (
        output en, frame_tick, point_left, point_right, restart,
        input  run, serve, serve_dir, s1, s2, gameover, win_left, win_right
    );

    modport slave (
        input  en, frame_tick, point_left, point_right, restart,
        output run, serve, serve_dir, s1, s2, gameover, win_left, win_right
    );

endinterface

// File: rtl/match_controller_frame_timer.sv
// Loadable frame down-counter shared by the warm-up and post-point pauses.
module frame_timer
    import match_controller_pkg::*;
#(
    parameter int RESET_VAL = 60
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [TIMER_W-1:0] load_val_i,
    input  logic               tick_i,
    input  logic               en_i,
    output logic               done_o,
    output logic               expire_o
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    // Next count: a load wins; otherwise count enabled ticks down to zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && tick_i && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= TIMER_W'(RESET_VAL);
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o   = (count_q == '0);
    // Lets the sequencer leave on the same edge the last tick lands, so SERVE
    // follows the final tick by exactly one cycle.
    assign expire_o = en_i && (done_o || (tick_i && (count_q == TIMER_W'(1))));

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: warm-up, serve, rally, pause and game-over phases,
// plus registered scores, serve direction and winner flags.
module match_controller
    import match_controller_pkg::*;
#(
    parameter int WARMUP_FRAMES = 60,
    parameter int PAUSE_FRAMES  = 30,
    parameter int WIN_SCORE     = 7
) (
    input  logic               clk,
    input  logic               rst,
    match_controller_if.slave  bus
);

    localparam logic [TIMER_W-1:0] WARMUP_LOAD = TIMER_W'(WARMUP_FRAMES);
    localparam logic [TIMER_W-1:0] PAUSE_LOAD  = TIMER_W'(PAUSE_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_Q       = SCORE_W'(WIN_SCORE);

    match_state_t       state_q, state_d;
    logic [SCORE_W-1:0] s1_q, s1_d;
    logic [SCORE_W-1:0] s2_q, s2_d;
    logic               dir_q, dir_d;
    logic               run_q, run_d;
    logic               serve_q, serve_d;
    logic               over_q, over_d;
    logic               win_left_q, win_left_d;
    logic               win_right_q, win_right_d;

    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_done;
    logic               timer_expire;

    frame_timer #(
        .RESET_VAL (WARMUP_FRAMES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .tick_i     (bus.frame_tick),
        .en_i       (bus.en),
        .done_o     (timer_done),
        .expire_o   (timer_expire)
    );

    // Next-state, score and timer-load decisions; restart overrides everything.
    always_comb begin
        state_d    = state_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        dir_d      = dir_q;
        timer_load = 1'b0;
        timer_val  = WARMUP_LOAD;

        if (bus.restart) begin
            state_d    = MS_WARMUP;
            s1_d       = '0;
            s2_d       = '0;
            dir_d      = 1'b0;
            timer_load = 1'b1;
        end else if (bus.en) begin
            unique case (state_q)
                MS_WARMUP, MS_PAUSE: begin
                    if (timer_expire) begin
                        state_d = MS_SERVE;
                    end
                end
                MS_SERVE: begin
                    state_d = MS_PLAY;
                end
                MS_PLAY: begin
                    if (bus.point_left || bus.point_right) begin
                        if (bus.point_left) begin
                            s1_d = sat_inc(s1_q, WIN_Q);
                        end
                        if (bus.point_right) begin
                            s2_d = sat_inc(s2_q, WIN_Q);
                        end
                        // Serve goes toward whoever conceded; a double point keeps it.
                        if (bus.point_left ^ bus.point_right) begin
                            dir_d = bus.point_left;
                        end
                        if ((s1_d == WIN_Q) || (s2_d == WIN_Q)) begin
                            state_d = MS_OVER;
                        end else begin
                            state_d    = MS_PAUSE;
                            timer_load = 1'b1;
                            timer_val  = PAUSE_LOAD;
                        end
                    end
                end
                MS_OVER: begin
                    state_d = MS_OVER;
                end
                default: begin
                    state_d = MS_WARMUP;
                end
            endcase
        end
    end

    // Registered outputs derived from the upcoming state so they align with it.
    always_comb begin
        run_d       = (state_d == MS_PLAY) && bus.en;
        // Entry into SERVE only happens on an enabled cycle, so the pulse marks entry.
        serve_d     = (state_d == MS_SERVE) && (state_q != MS_SERVE);
        over_d      = (state_d == MS_OVER);
        win_left_d  = (state_d == MS_OVER) && (s1_d == WIN_Q);
        win_right_d = (state_d == MS_OVER) && (s2_d == WIN_Q);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MS_WARMUP;
            s1_q        <= '0;
            s2_q        <= '0;
            dir_q       <= 1'b0;
            run_q       <= 1'b0;
            serve_q     <= 1'b0;
            over_q      <= 1'b0;
            win_left_q  <= 1'b0;
            win_right_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            dir_q       <= dir_d;
            run_q       <= run_d;
            serve_q     <= serve_d;
            over_q      <= over_d;
            win_left_q  <= win_left_d;
            win_right_q <= win_right_d;
        end
    end

    assign bus.run       = run_q;
    assign bus.serve     = serve_q;
    assign bus.serve_dir = dir_q;
    assign bus.s1        = s1_q;
    assign bus.s2        = s2_q;
    assign bus.gameover  = over_q;
    assign bus.win_left  = win_left_q;
    assign bus.win_right = win_right_q;

endmodule

// File: tb/tb_match_controller.sv
// Randomised and directed checks of match_controller against a phase-level model.
module tb_match_controller;

    localparam int WARMUP = 3;
    localparam int PAUSE  = 2;
    localparam int WIN    = 7;

    localparam int PH_WAIT  = 0;
    localparam int PH_SERVE = 1;
    localparam int PH_PLAY  = 2;
    localparam int PH_OVER  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    match_controller_if bus_if ();

    match_controller #(
        .WARMUP_FRAMES (WARMUP),
        .PAUSE_FRAMES  (PAUSE),
        .WIN_SCORE     (WIN)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_phase;
    int m_left;
    int m_s1, m_s2, m_dir;
    int m_serve, m_run;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_WAIT;
        m_left  = WARMUP;
        m_s1 = 0; m_s2 = 0; m_dir = 0;
        m_serve = 0; m_run = 0;
    endtask

    task automatic model_step(input logic e, input logic t, input logic pl,
                              input logic pr, input logic rs);
        m_serve = 0;
        if (rs) begin
            m_s1 = 0; m_s2 = 0; m_dir = 0;
            m_phase = PH_WAIT;
            m_left  = WARMUP;
        end else if (e) begin
            case (m_phase)
                PH_WAIT: begin
                    if (m_left > 0 && t) m_left--;
                    if (m_left == 0) begin
                        m_phase = PH_SERVE;
                        m_serve = 1;
                    end
                end
                PH_SERVE: m_phase = PH_PLAY;
                PH_PLAY: begin
                    if (pl || pr) begin
                        if (pl) m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
                        if (pr) m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
                        if (pl != pr) m_dir = pl ? 1 : 0;
                        if (m_s1 == WIN || m_s2 == WIN) begin
                            m_phase = PH_OVER;
                        end else begin
                            m_phase = PH_WAIT;
                            m_left  = PAUSE;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_run = (m_phase == PH_PLAY && e) ? 1 : 0;
    endtask

    task automatic check_outputs(input string tag);
        int over;
        over = (m_phase == PH_OVER) ? 1 : 0;
        check({tag, ".run"},       8'(bus_if.run),       8'(m_run));
        check({tag, ".serve"},     8'(bus_if.serve),     8'(m_serve));
        check({tag, ".serve_dir"}, 8'(bus_if.serve_dir), 8'(m_dir));
        check({tag, ".s1"},        8'(bus_if.s1),        8'(m_s1));
        check({tag, ".s2"},        8'(bus_if.s2),        8'(m_s2));
        check({tag, ".gameover"},  8'(bus_if.gameover),  8'(over));
        check({tag, ".win_left"},  8'(bus_if.win_left),  8'(over != 0 && m_s1 == WIN));
        check({tag, ".win_right"}, 8'(bus_if.win_right), 8'(over != 0 && m_s2 == WIN));
    endtask

    // One clock: drive inputs, advance model on the edge, compare on the falling edge.
    task automatic step(input logic e, input logic t, input logic pl,
                        input logic pr, input logic rs, input string tag);
        bus_if.en          = e;
        bus_if.frame_tick  = t;
        bus_if.point_left  = pl;
        bus_if.point_right = pr;
        bus_if.restart     = rs;
        @(posedge clk);
        model_step(e, t, pl, pr, rs);
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic wait_run();
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (bus_if.run) seen = 1;
            else step(1, 1, 0, 0, 0, "wait_run");
        end
        check("wait_run_in_budget", 8'(seen), 8'd1);
    endtask

    task automatic play_point(input logic pl, input logic pr);
        wait_run();
        step(1, 0, pl, pr, 0, "point");
        $display("point l=%0d r=%0d -> s1=%0d s2=%0d dir=%0d over=%0d",
                 pl, pr, bus_if.s1, bus_if.s2, bus_if.serve_dir, bus_if.gameover);
    endtask

    initial begin
        int  ticks;
        bit  found;
        logic e, t, pl, pr, rs;

        bus_if.en = 0; bus_if.frame_tick = 0; bus_if.point_left = 0;
        bus_if.point_right = 0; bus_if.restart = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;

        // Warm-up: tick every 10 cycles, serve exactly after the third tick.
        ticks = 0; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            t = (i % 10 == 9);
            step(1, t, 0, 0, 0, "warmup");
            if (t) ticks++;
            if (bus_if.serve) found = 1;
        end
        check("warmup_serve_seen", 8'(found), 8'd1);
        check("warmup_ticks", 8'(ticks), 8'(WARMUP));
        step(1, 0, 0, 0, 0, "first_play");
        check("first_play_run", 8'(bus_if.run), 8'd1);
        $display("warmup: serve after %0d ticks", ticks);

        // Left point, then a pulse during PAUSE that must be ignored.
        step(1, 0, 1, 0, 0, "left_point");
        check("left_point_s1", 8'(bus_if.s1), 8'd1);
        check("left_point_dir", 8'(bus_if.serve_dir), 8'd1);
        check("left_point_run", 8'(bus_if.run), 8'd0);
        step(1, 0, 1, 0, 0, "pause_pulse");
        check("pause_pulse_s1", 8'(bus_if.s1), 8'd1);
        ticks = 0; found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            t = (i % 2 == 1);
            step(1, t, 0, 0, 0, "pause");
            if (t) ticks++;
            if (bus_if.serve) found = 1;
        end
        check("pause_serve_seen", 8'(found), 8'd1);
        check("pause_ticks", 8'(ticks), 8'(PAUSE));
        $display("pause: serve after %0d ticks", ticks);

        // Seven right points end the match.
        step(1, 0, 0, 0, 1, "restart1");
        check("restart1_s1", 8'(bus_if.s1), 8'd0);
        for (int i = 0; i < WIN; i++) play_point(0, 1);
        check("right_win_s2", 8'(bus_if.s2), 8'(WIN));
        check("right_win_over", 8'(bus_if.gameover), 8'd1);
        check("right_win_wr", 8'(bus_if.win_right), 8'd1);
        check("right_win_wl", 8'(bus_if.win_left), 8'd0);
        for (int i = 0; i < 5; i++) step(1, 1, 1, 1, 0, "over_pulses");
        check("over_hold_s2", 8'(bus_if.s2), 8'(WIN));
        check("over_hold_s1", 8'(bus_if.s1), 8'd0);

        // 6:6 then a simultaneous point -> draw, serve_dir held.
        step(1, 0, 0, 0, 1, "restart2");
        for (int i = 0; i < WIN - 1; i++) play_point(0, 1);
        for (int i = 0; i < WIN - 1; i++) play_point(1, 0);
        check("six_all_dir", 8'(bus_if.serve_dir), 8'd1);
        play_point(1, 1);
        check("draw_s1", 8'(bus_if.s1), 8'(WIN));
        check("draw_s2", 8'(bus_if.s2), 8'(WIN));
        check("draw_over", 8'(bus_if.gameover), 8'd1);
        check("draw_wl", 8'(bus_if.win_left), 8'd1);
        check("draw_wr", 8'(bus_if.win_right), 8'd1);
        check("draw_dir", 8'(bus_if.serve_dir), 8'd1);

        // en low for 50 cycles mid-warm-up with ticks present.
        step(1, 0, 0, 0, 1, "restart3");
        step(1, 1, 0, 0, 0, "warm_tick1");
        for (int i = 0; i < 50; i++) begin
            step(0, 1, 0, 0, 0, "en_low");
            check("en_low_serve", 8'(bus_if.serve), 8'd0);
        end
        ticks = 0; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1, 1, 0, 0, 0, "en_resume");
            ticks++;
            if (bus_if.serve) found = 1;
        end
        check("en_resume_serve", 8'(found), 8'd1);
        check("en_resume_ticks", 8'(ticks), 8'(WARMUP - 1));
        $display("en freeze: serve after %0d more ticks", ticks);

        // Restart from PAUSE with s1=4.
        step(1, 0, 0, 0, 1, "restart4");
        for (int i = 0; i < 4; i++) play_point(1, 0);
        check("pre_restart_s1", 8'(bus_if.s1), 8'd4);
        step(1, 0, 0, 0, 1, "restart_pause");
        check("restart_pause_s1", 8'(bus_if.s1), 8'd0);
        check("restart_pause_dir", 8'(bus_if.serve_dir), 8'd0);

        // Asynchronous reset in the middle of PLAY.
        play_point(1, 0);
        wait_run();
        bus_if.en = 1; bus_if.frame_tick = 0; bus_if.point_left = 0;
        bus_if.point_right = 0; bus_if.restart = 0;
        @(posedge clk);
        model_step(1, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_s1", 8'(bus_if.s1), 8'd0);
        check("async_rst_run", 8'(bus_if.run), 8'd0);
        check_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        $display("async reset: outputs cleared mid-cycle");

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            e  = ($urandom_range(9, 0) != 0);
            t  = ($urandom_range(2, 0) == 0);
            pl = ($urandom_range(5, 0) == 0);
            pr = ($urandom_range(5, 0) == 0);
            rs = ($urandom_range(299, 0) == 0);
            step(e, t, pl, pr, rs, "random");
        end
        $display("random: 3000 cycles done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
